// File: rtl/baud_pkg.sv
// Shared constants, divisor type and default-divisor helper for the baud
// tick generator family.
package baud_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned FRAC_W_DEF     = 8;

  // Divisor as {integer clocks per oversample tick, fraction in 2^-FRAC_W}
  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

  // floor(clk_hz * 2^frac_w / (baud * oversample)); frac_w = 0 gives the
  // plain integer divisor.
  function automatic longint unsigned calc_default_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned oversample,
    input int unsigned     frac_w
  );
    return (clk_hz << frac_w) / (baud * oversample);
  endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional phase accumulator: adds the fraction at every period end and
// presents the overflow as a registered carry that lengthens the next period
// by one clock.
module baud_frac_accum #(
  parameter int unsigned FRAC_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);

  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [FRAC_W:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
  assign o_carry = r_carry;

  // Accumulate on period-end strobes; reset and resync clear the phase.
  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_step) begin
      r_acc   <= w_sum[FRAC_W-1:0];
      r_carry <= w_sum[FRAC_W];
    end
  end

endmodule

// File: rtl/baud_tick_gen_frac.sv
// Programmable baud tick generator: oversample, bit and mid-bit ticks from one
// divider, with a runtime divisor load/ack handshake and RX phase resync.
// Build option: define BAUD_FRAC_EN to add the fractional accumulator;
// without it the fraction input is ignored and the period is div_int.
module baud_tick_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DEFAULT_BAUD = 19200,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W        = DIV_W_DEF,
  parameter int unsigned FRAC_W       = FRAC_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  output logic              o_div_ack,
  output logic              o_div_err,
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_bit_tick,
  output logic              o_mid_tick
);

  localparam int unsigned SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

`ifdef BAUD_FRAC_EN
  localparam longint unsigned DEF_D =
    calc_default_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_D >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_D);
`else
  localparam longint unsigned DEF_D =
    calc_default_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE, 0);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_D);
  localparam logic [FRAC_W-1:0] DEF_FRAC = '0;
`endif

  typedef struct packed {
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } div_t;

  div_t             r_div;
  div_t             r_pend_div;
  logic             r_pend;
  logic             r_ack;
  logic             r_err;
  logic [DIV_W-1:0] r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic             r_os;
  logic             r_bit;
  logic             r_mid;

  div_t             w_new;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_carry;
  logic [DIV_W:0]   w_last;
  logic             w_end;

  assign w_new.div_int = i_div_int;
`ifdef BAUD_FRAC_EN
  assign w_new.div_frac = i_div_frac;

  baud_frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_accum (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_resync),
    .i_step  (w_end),
    .i_frac  (r_div.div_frac),
    .o_carry (w_carry)
  );
`else
  logic w_unused_frac;
  assign w_new.div_frac = '0;
  assign w_carry        = 1'b0;
  assign w_unused_frac  = ^{i_div_frac, r_div.div_frac};
`endif

  assign w_load_ok  = i_div_load && (i_div_int >= DIV_W'(2));
  assign w_load_bad = i_div_load && (i_div_int <  DIV_W'(2));

  // Last count of the current period is div_int + carry - 1; ">=" keeps a
  // divisor shrunk while disabled from running past its end.
  assign w_last = {1'b0, r_div.div_int} + {{DIV_W{1'b0}}, w_carry} - (DIV_W+1)'(1);
  assign w_end  = i_enable && !i_resync && ({1'b0, r_cnt} >= w_last);

  // Divisor register, pending-load capture and apply/ack/err pulses.
  // The period-end apply uses only a previously captured request; a load
  // arriving in that same cycle stays pending for the next period end.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_div      <= '{div_int: DEF_INT, div_frac: DEF_FRAC};
      r_pend_div <= '0;
      r_pend     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= w_load_bad;
      if (w_load_ok) begin
        r_pend     <= 1'b1;
        r_pend_div <= w_new;
      end
      if (i_resync && (r_pend || w_load_ok)) begin
        r_div  <= w_load_ok ? w_new : r_pend_div;
        r_pend <= 1'b0;
        r_ack  <= 1'b1;
      end else if (r_pend && (!i_enable || w_end)) begin
        r_div  <= r_pend_div;
        r_pend <= w_load_ok;
        r_ack  <= 1'b1;
      end
    end
  end

  // Cycle and oversample counters with registered one-cycle tick outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_cnt <= '0;
      r_sub <= '0;
      r_os  <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
    end else begin
      r_os  <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
      if (i_resync) begin
        r_cnt <= '0;
        r_sub <= '0;
      end else if (w_end) begin
        r_cnt <= '0;
        r_os  <= 1'b1;
        r_bit <= (r_sub == SUB_LAST);
        r_mid <= (r_sub == SUB_MID);
        r_sub <= (r_sub == SUB_LAST) ? '0 : r_sub + SUB_W'(1);
      end else if (i_enable) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign o_div_ack  = r_ack;
  assign o_div_err  = r_err;
  assign o_os_tick  = r_os;
  assign o_bit_tick = r_bit;
  assign o_mid_tick = r_mid;

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Directed bench for baud_tick_gen_frac with a period scoreboard fed by a
// behavioural divider/accumulator model. Honors BAUD_FRAC_EN like the RTL.
module tb_baud_tick_gen_frac;

`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic        resync;
  logic [15:0] di;
  logic [7:0]  df;
  logic        ack, err, os_t, bit_t, mid_t;

  int checks = 0;
  int errors = 0;

  int m_int, m_frac, m_acc, m_carry, m_sub;

  typedef struct {
    int per;
    int ack;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  baud_tick_gen_frac dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_enable   (en),
    .i_div_int  (di),
    .i_div_frac (df),
    .i_div_load (load),
    .o_div_ack  (ack),
    .o_div_err  (err),
    .i_resync   (resync),
    .o_os_tick  (os_t),
    .o_bit_tick (bit_t),
    .o_mid_tick (mid_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of one period end: accumulate the fraction in force during it.
  task automatic model_end();
    int sum;
    if (FRAC_ON) begin
      sum     = m_acc + m_frac;
      m_carry = sum / 256;
      m_acc   = sum % 256;
    end
  endtask

  task automatic push_exp(input int per, input int ack_flag);
    exp_t e;
    e.per = per;
    e.ack = ack_flag;
    exp_q.push_back(e);
  endtask

  task automatic push_periods(input int n, input int ack_first);
    for (int i = 0; i < n; i++) begin
      push_exp(m_int + m_carry, (i == 0) ? ack_first : 0);
      model_end();
    end
  endtask

  task automatic wait_tick(input int start, output int cyc, output int acks,
                           output int errs, output int stray, output int ok);
    cyc = start; acks = 0; errs = 0; stray = 0; ok = 0;
    while (ok == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (ack === 1'b1) acks++;
      if (err === 1'b1) errs++;
      if (os_t === 1'b1) ok = 1;
      else if (bit_t === 1'b1 || mid_t === 1'b1) stray++;
    end
  endtask

  task automatic run_ticks(input int n, input int start, input int base,
                           output int sum, output int longs);
    int cyc, acks, errs, stray, ok;
    exp_t e;
    sum = 0; longs = 0;
    for (int i = 0; i < n; i++) begin
      wait_tick((i == 0) ? start : 0, cyc, acks, errs, stray, ok);
      chk("tick_seen", ok, 1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e.per = -1; e.ack = -1; end
      chk("os_period", cyc, e.per);
      chk("ack_at_tick", ack, e.ack);
      chk("ack_count", acks, e.ack);
      chk("err_count", errs, 0);
      chk("stray_bit_mid", stray, 0);
      chk("bit_tick", bit_t, (m_sub == OS - 1));
      chk("mid_tick", mid_t, (m_sub == OS / 2 - 1));
      m_sub = (m_sub + 1) % OS;
      sum += cyc;
      if (cyc == base + 1) longs++;
    end
  endtask

  task automatic pulse_load(input int d_int, input int d_frac, input int exp_err);
    load = 1'b1;
    di   = d_int[15:0];
    df   = d_frac[7:0];
    @(negedge clk);
    load = 1'b0;
    chk("load_err", err, exp_err);
    chk("load_no_ack", ack, 0);
    chk("load_no_tick", os_t, 0);
  endtask

  initial begin
    int sum, longs;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; resync = 1'b0; di = '0; df = '0;
    m_int = 325; m_frac = FRAC_ON ? 133 : 0; m_acc = 0; m_carry = 0; m_sub = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_os", os_t, 0);
    chk("rst_bit", bit_t, 0);
    chk("rst_mid", mid_t, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Default divisor: first tick on the 325th edge, then 256 periods
    push_periods(1, 0);
    run_ticks(1, 0, 325, sum, longs);
    push_periods(256, 0);
    run_ticks(256, 0, 325, sum, longs);
    chk("default_256_total", sum, FRAC_ON ? 83333 : 83200);
    chk("default_256_long", longs, FRAC_ON ? 133 : 0);

    // Load int=4 frac=0: ack with the current period's end tick
    push_periods(1, 1);
    m_int = 4; m_frac = 0;
    pulse_load(4, 0, 0);
    run_ticks(1, 1, 0, sum, longs);
    push_periods(40, 0);
    run_ticks(40, 0, 4, sum, longs);

    // Load int=4 frac=128: steady 64-period window
    push_periods(1, 1);
    m_frac = FRAC_ON ? 128 : 0;
    pulse_load(4, 128, 0);
    run_ticks(1, 1, 0, sum, longs);
    push_periods(1, 0);
    run_ticks(1, 0, 4, sum, longs);
    push_periods(64, 0);
    run_ticks(64, 0, 4, sum, longs);
    chk("frac128_64_total", sum, FRAC_ON ? 288 : 256);

    // Rejected load int=1: err next cycle, no ack, divisor unchanged
    push_periods(1, 0);
    pulse_load(1, 0, 1);
    run_ticks(1, 1, 0, sum, longs);
    push_periods(2, 0);
    run_ticks(2, 0, 4, sum, longs);

    // Resync at cnt=2 with a simultaneous load int=6
    @(negedge clk);
    chk("pre_resync_no_tick1", os_t, 0);
    @(negedge clk);
    chk("pre_resync_no_tick2", os_t, 0);
    resync = 1'b1; load = 1'b1; di = 16'd6; df = 8'd0;
    @(negedge clk);
    resync = 1'b0; load = 1'b0;
    chk("resync_ack", ack, 1);
    chk("resync_no_tick", os_t, 0);
    chk("resync_no_err", err, 0);
    m_int = 6; m_frac = 0; m_acc = 0; m_carry = 0; m_sub = 0;
    push_periods(3, 0);
    run_ticks(3, 0, 6, sum, longs);

    // Back to int=4, then hold enable low at cnt=1 with a load while idle
    push_periods(1, 1);
    m_int = 4;
    pulse_load(4, 0, 0);
    run_ticks(1, 1, 0, sum, longs);
    @(negedge clk);
    chk("pre_disable_no_tick", os_t, 0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("disabled_no_tick", os_t, 0);
      chk("disabled_ack", ack, (i == 3));
      if (i == 1) begin load = 1'b1; di = 16'd4; df = 8'd0; end
      if (i == 2) load = 1'b0;
    end
    en = 1'b1;
    push_exp(3, 0);
    model_end();
    push_periods(4, 0);
    run_ticks(5, 0, 4, sum, longs);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen_frac.md
Name: baud_tick_gen_frac

Overview:
- Programmable fractional baud tick generator; parametrised successor of the fixed-divisor UART rate generator.
- Produces an oversample tick, a bit tick and a mid-bit tick from one divider.
- The divisor can be reloaded at runtime through a load/ack handshake.
- Sits between i_clock and the UART RX/TX FSMs; RX drives i_resync on start-bit edge for sample alignment.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- DEFAULT_BAUD, 19200, baud rate applied at reset.
- OVERSAMPLE, 16, oversample ticks per bit; even, >= 4.
- DIV_W, 16, integer divisor width.
- FRAC_W, 8, fractional divisor width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_enable  in  1  run counters; low = hold all state, ticks forced 0.
- i_div_int  in  DIV_W  integer part of clocks per oversample tick.
- i_div_frac  in  FRAC_W  fractional part, units of 2^-FRAC_W.
- i_div_load  in  1  request to load the divisor inputs.
- o_div_ack  out  1  one-cycle pulse: new divisor applied.
- o_div_err  out  1  one-cycle pulse: load rejected (i_div_int < 2).
- i_resync  in  1  restart phase: clear all counters and the accumulator.
- o_os_tick  out  1  oversample tick, one cycle wide.
- o_bit_tick  out  1  bit-period tick, one cycle wide.
- o_mid_tick  out  1  mid-bit tick, one cycle wide.

Behaviour:
- Reset (i_reset=0 at a rising edge) clears all outputs, counters and the accumulator.
- Reset loads the divisor register with D = floor(CLK_HZ*2^FRAC_W/(DEFAULT_BAUD*OVERSAMPLE)), where int = D>>FRAC_W and frac = D low bits.
- Cycle counter cnt: counts 0..P-1, where period P = div_int + carry.
  - carry is registered from the previous period end's accumulator add: acc + frac >= 2^FRAC_W.
  - acc wraps mod 2^FRAC_W.
- o_os_tick is registered and high for exactly one cycle at each period end.
  - With i_enable held high after reset, the first tick occurs on the div_int-th enabled edge.
- Sub counter sub: counts 0..OVERSAMPLE-1 on os ticks and wraps.
  - o_bit_tick coincides with the os tick where sub = OVERSAMPLE-1.
  - o_mid_tick coincides with the os tick where sub = OVERSAMPLE/2-1.
- Divisor load handshake:
  - The pending request is captured when i_div_load=1.
  - It is applied at the next period end, or on the next edge if i_enable=0.
  - o_div_ack pulses in the apply cycle.
  - A further load while one is pending overwrites the pending value; only one ack is issued.
  - Values are checked at capture; div_int < 2 gives o_div_err the next cycle, no ack, and the old divisor is kept.
- i_resync:
  - cnt, sub and acc are cleared and carry is cleared.
  - No tick is issued in the resync cycle.
  - The next os tick comes div_int cycles later.
  - A load that is pending or simultaneous is applied immediately, with ack in the same cycle.
- Priority: reset > resync > enable low > normal counting.
- Enable low mid-period: cnt, sub and acc are frozen; counting resumes where it stopped.

Optional Feature:
- Macro: BAUD_FRAC_EN.
- Defined: fractional accumulator present, behaviour as above.
- Undefined: i_div_frac is ignored, carry is tied to 0, acc is removed, P = div_int, and the reset divisor is floor(CLK_HZ/(DEFAULT_BAUD*OVERSAMPLE)).

Decomposition:
- Package baud_pkg holds:
  - default OVERSAMPLE, DIV_W and FRAC_W constants;
  - a function computing the default divisor from CLK_HZ, baud, OVERSAMPLE and FRAC_W;
  - a typedef for the {int, frac} divisor struct.
- One sub-module, baud_frac_accum: holds acc, takes frac and a period-end strobe, outputs registered carry. It is instantiated only under BAUD_FRAC_EN.

Test Plan:
- Reset with defaults, BAUD_FRAC_EN defined -> divisor int=325, frac=133; over 256 os periods there are 83333 cycles total, and exactly 133 periods are 326 long.
- Load int=4, frac=0 -> ack at next period end; then os tick every 4 cycles, bit tick every 64, mid tick 32 cycles before each bit tick.
- Load int=4, frac=128 -> period sequence after ack is 4,4,5,4,5,...; 64 periods total 288 cycles.
- Load int=1 -> o_div_err pulse next cycle, no ack, old period unchanged.
- Assert i_resync at cnt=2 with int=4, simultaneous with load int=6 -> ack in the same cycle, no tick; next os tick 6 cycles later, sub restarts at 0.
- Drop i_enable for 10 cycles mid-period (int=4, cnt=1) -> no ticks; after re-enable the tick arrives 3 cycles later.
